frame_streamer: RTL
===================

// Module: frame_streamer
// PURPOSE
//  Reader end of the sample-frame ring BRAM. The oversampler side writes one sample per
//  done pulse at fhead. On start, this block snapshots fhead and reads the most recent
//  2^ADDR_W samples, oldest first. It streams them as a valve-style stream (tvalid/tready/tlast)
//  into the FFT input, with full backpressure support.
// PARAMETERS
//  ADDR_W      12  frame address width; frame length N = 2^ADDR_W samples
//  DATA_W      16  sample width, frame BRAM data and stream data
//  SIGNED_OUT  1   1: invert MSB (offset-binary -> two's complement); 0: pass through
// PORTS
//  clk       in   1       system clock (same domain as frame BRAM read port)
//  reset     in   1       synchronous, active-high reset
//  start     in   1       request one frame; sampled only in IDLE
//  fhead     in   ADDR_W  writer head = address of oldest sample in ring
//  faddr     out  ADDR_W  frame BRAM read address (registered)
//  fdata     in   DATA_W  frame BRAM read data, valid 1 cycle after faddr
//  m_tdata   out  DATA_W  stream sample
//  m_tvalid  out  1       stream valid
//  m_tready  in   1       stream ready from FFT
//  m_tlast   out  1       high on beat N-1 of the frame
//  busy      out  1       high from start acceptance until last handshake
//  overrun   out  1       1-cycle pulse: start seen while busy (request dropped)
// BEHAVIOUR
//  - Reset values: faddr=0, m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, overrun=0.
//    Internal FIFO is emptied, in-flight reads are discarded, and the FSM goes to IDLE.
//  - FSM states:
//    - IDLE: on start, latch base=fhead, clear read count rk and beat count bk,
//      set busy, and go to READ.
//    - READ: issue reads while rk<N. Go to DRAIN once rk reaches N.
//    - DRAIN: wait for the beat with bk=N-1 to handshake, then clear busy and go to IDLE.
//  - Read address: faddr = base + rk mod 2^ADDR_W. Wrap is natural overflow.
//    base=0xFFF, N=4096 reads 0xFFF, 0x000, ... 0xFFE.
//  - Read issue rule: issue when (fifo_count + inflight) < 2.
//    - The 2-entry output FIFO absorbs the 1-cycle BRAM latency.
//    - No sample is ever lost or duplicated under any tready pattern.
//  - Output: m_tdata = fifo head, with MSB inverted if SIGNED_OUT.
//    m_tlast = (bk == N-1) with m_tvalid.
//    - While m_tvalid && !m_tready: m_tdata and m_tlast hold stable and m_tvalid stays high.
//    - A handshake is m_tvalid && m_tready; it increments bk.
//  - Latency: start sampled at edge E gives faddr=base after E+1 and first m_tvalid
//    after E+3.
//    - With m_tready held high, beats are on consecutive cycles and m_tlast comes after
//      edge E+N+2.
//    - busy falls at the edge that completes the tlast handshake.
//  - Simultaneous events:
//    - start while busy (including the tlast-handshake cycle): request ignored,
//      overrun=1 for 1 cycle.
//    - start in IDLE uses fhead from that same cycle.
//  - fhead changes after the start edge are ignored until the next start.
//    - Ring overwrite during a stream is not guarded. The writer rate (~3.9 kS/s) is far
//      below the read rate.
//  - Reset mid-frame: m_tvalid=0 next cycle and no partial tlast is emitted.
//    The next start begins a full frame.
// TESTING
//  1 fill ring addr i -> i, fhead=0, tready=1, pulse start -> N beats 0..4095 (MSB
//    flipped), tvalid first at E+3, tlast only on beat 4095, busy falls after it
//  2 fhead=0xFF0 -> beats start 0xFF0, wrap to 0x000 at beat 16, last beat data 0xFEF
//  3 tready random 50% and 5-cycle stalls -> exact 0..N-1 sequence, no dup/drop,
//    tdata/tlast stable while stalled
//  4 start pulsed mid-frame and on the tlast cycle -> overrun 1-cycle pulse each,
//    frame unaffected, no second frame
//  5 reset asserted at beat 100 -> tvalid=0, busy=0 next cycle; new start streams full N
//  6 SIGNED_OUT=0, fdata=0x8000 -> m_tdata=0x8000; SIGNED_OUT=1 -> 0x0000

Source files
------------

// File: rtl/frame_streamer_if.sv
// AXI-Stream-style sample stream (tdata/tvalid/tready/tlast) carried from the frame reader to the FFT.
interface frame_streamer_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_streamer.sv
// Reads the newest 2^ADDR_W samples from the frame ring BRAM, oldest first,
// and streams them with full backpressure through a registered output stage plus 2-entry skid FIFO.
module frame_streamer #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 16,
    parameter bit          SIGNED_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] fhead,
    output logic [ADDR_W-1:0] faddr,
    input  logic [DATA_W-1:0] fdata,
    frame_streamer_if.master  m,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  N_RD      = CNT_W'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_BEAT = '1;
    localparam logic [DATA_W-1:0] MSB_MASK  =
        SIGNED_OUT ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  rk_q;
    logic [ADDR_W-1:0] lk_q;
    logic              s1_q, s2_q;
    logic [DATA_W-1:0] fifo_q [2];
    logic              wp_q, rp_q;
    logic [1:0]        fcnt_q;
    logic [ADDR_W-1:0] faddr_q;
    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q, tlast_q;
    logic              busy_q, overrun_q;

    logic              out_free_c, pop_c, issue_c, load_fifo_c, load_cap_c, push_c, done_c;
    logic [2:0]        occ_c;
    logic [DATA_W-1:0] sample_c;

    // Credit check: skid entries plus reads in the two BRAM stages, with one slot
    // returned when the output register is free this cycle; keeps back-to-back beats
    // at full rate while never exceeding the two skid entries.
    always_comb begin
        out_free_c  = !tvalid_q || m.tready;
        pop_c       = tvalid_q && m.tready;
        occ_c       = 3'(fcnt_q) + 3'(s1_q) + 3'(s2_q);
        issue_c     = (state_q == S_READ) && (rk_q < N_RD) && (occ_c < (3'd2 + 3'(out_free_c)));
        load_fifo_c = out_free_c && (fcnt_q != 2'd0);
        load_cap_c  = out_free_c && (fcnt_q == 2'd0) && s2_q;
        push_c      = s2_q && !load_cap_c;
        done_c      = pop_c && tlast_q;
        sample_c    = fdata ^ MSB_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            rk_q      <= '0;
            lk_q      <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            fcnt_q    <= '0;
            faddr_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= start && (state_q != S_IDLE);
            s1_q      <= issue_c;
            s2_q      <= s1_q;

            if (issue_c) begin
                faddr_q <= base_q + rk_q[ADDR_W-1:0];
                rk_q    <= rk_q + CNT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= fhead;
                        rk_q    <= '0;
                        lk_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (rk_q == N_RD) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (done_c) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Output register refills from the skid FIFO first to preserve order.
            if (load_fifo_c) begin
                tdata_q  <= fifo_q[rp_q];
                rp_q     <= ~rp_q;
                tvalid_q <= 1'b1;
                tlast_q  <= (lk_q == LAST_BEAT);
                lk_q     <= lk_q + ADDR_W'(1);
            end else if (load_cap_c) begin
                tdata_q  <= sample_c;
                tvalid_q <= 1'b1;
                tlast_q  <= (lk_q == LAST_BEAT);
                lk_q     <= lk_q + ADDR_W'(1);
            end else if (pop_c) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            if (push_c) wp_q <= ~wp_q;
            fcnt_q <= fcnt_q + 2'(push_c) - 2'(load_fifo_c);
        end
    end

    // Skid storage holds data only; occupancy is tracked by fcnt_q.
    always_ff @(posedge clk) begin
        if (push_c) fifo_q[wp_q] <= sample_c;
    end

    assign faddr    = faddr_q;
    assign m.tdata  = tdata_q;
    assign m.tvalid = tvalid_q;
    assign m.tlast  = tlast_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
